// File: rtl/ntt_io_pkg.sv
// ntt_io_pkg: shared FSM state type, default widths and the bit-reverse
// helper used by the NTT coefficient I/O block.
package ntt_io_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_ADW        = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNLOAD = 2'd2
  } io_state_t;

  // Reverse the lowest 'width' bits of 'value'; upper bits come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r[i] = value[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/coef_skid_fifo.sv
// coef_skid_fifo: 2-entry FIFO that holds RAM read data for the output
// coefficient stream. The head entry drives the stream and only moves on a
// pop, so data and last stay stable under backpressure.
module coef_skid_fifo #(
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] tail_data;
  logic             head_last;
  logic             tail_last;
  logic [1:0]       count;
  logic             pop;

  assign valid_o = (count != 2'd0);
  assign pop     = valid_o & pop_ready_i;
  assign data_o  = head_data;
  assign last_o  = head_last & valid_o;
  assign count_o = count;

  // Push/pop bookkeeping; the writer never pushes into a full FIFO without a pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_data <= '0;
      tail_data <= '0;
      head_last <= 1'b0;
      tail_last <= 1'b0;
      count     <= 2'd0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data_i;
            head_last <= push_last_i;
          end else begin
            tail_data <= push_data_i;
            tail_last <= push_last_i;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= push_data_i;
            head_last <= push_last_i;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data_i;
            tail_last <= push_last_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ntt_coef_io.sv
// ntt_coef_io: moves a full set of DEPTH = 2**ADW coefficients between the
// stream interfaces and RAM port A. LOAD writes the input stream into RAM,
// UNLOAD reads RAM in natural order into the output stream.
// Optional feature: define NTT_COEF_IO_BITREV_EN to store load beat k at the
// bit-reversed address of k instead of at address k.
module ntt_coef_io
  import ntt_io_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADW        = DEF_ADW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_load_i,
  input  logic                  start_unload_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  ram_we_o,
  output logic [ADW-1:0]        ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  localparam logic [ADW-1:0] LAST_ADDR = {ADW{1'b1}};

  io_state_t      state;
  logic [ADW-1:0] cnt;
  logic           cnt_done;
  logic           rd_pend1;
  logic           rd_pend2;
  logic           rd_last1;
  logic           rd_last2;
  logic [1:0]     fifo_count;
  logic [2:0]     in_use;
  logic           s_fire;
  logic           m_pop;
  logic           issue;
  logic [ADW-1:0] load_addr;

`ifdef NTT_COEF_IO_BITREV_EN
  assign load_addr = ADW'(bit_reverse(32'(cnt), ADW));
`else
  assign load_addr = cnt;
`endif

  assign busy_o    = (state != IDLE);
  assign s_ready_o = (state == LOAD) && !cnt_done;
  assign s_fire    = s_valid_i & s_ready_o;
  assign m_pop     = m_valid_o & m_ready_i;

  // Entries that will still need FIFO space after this edge: occupancy left
  // after the current pop plus both read pipeline stages. Keeping this below
  // two guarantees every read lands in a free FIFO slot.
  assign in_use = {1'b0, fifo_count} - {2'b00, m_pop} + {2'b00, rd_pend1} + {2'b00, rd_pend2};
  assign issue  = (state == UNLOAD) && !cnt_done && (in_use < 3'd2);

  coef_skid_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rd_pend2),
    .push_data_i (ram_dout_i),
    .push_last_i (rd_last2),
    .pop_ready_i (m_ready_i),
    .valid_o     (m_valid_o),
    .data_o      (m_data_o),
    .last_o      (m_last_o),
    .count_o     (fifo_count)
  );

  // Pass FSM with registered RAM drive, done pulse and read pipeline tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      cnt_done   <= 1'b0;
      done_o     <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_din_o  <= '0;
      rd_pend1   <= 1'b0;
      rd_pend2   <= 1'b0;
      rd_last1   <= 1'b0;
      rd_last2   <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      ram_we_o <= 1'b0;
      rd_pend1 <= issue;
      rd_last1 <= issue && (cnt == LAST_ADDR);
      rd_pend2 <= rd_pend1;
      rd_last2 <= rd_last1;
      case (state)
        IDLE: begin
          cnt      <= '0;
          cnt_done <= 1'b0;
          if (start_load_i) begin
            state <= LOAD;
          end else if (start_unload_i) begin
            state <= UNLOAD;
          end
        end
        LOAD: begin
          if (s_fire) begin
            ram_we_o   <= 1'b1;
            ram_addr_o <= load_addr;
            ram_din_o  <= s_data_i;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
              cnt_done <= 1'b1;
            end
          end else if (cnt_done) begin
            cnt_done <= 1'b0;
            done_o   <= 1'b1;
            state    <= IDLE;
          end
        end
        UNLOAD: begin
          if (issue) begin
            ram_addr_o <= cnt;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
              cnt_done <= 1'b1;
            end
          end
          if (m_pop && m_last_o) begin
            cnt_done <= 1'b0;
            done_o   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
